// File: rtl/tpu_sequencer.sv
// Instruction sequencer for the tiny TPU: fetches 16-bit instructions and drives the datapath strobes.
// Latency: 2 cycles per instruction (FETCH, DECODE) plus COMPUTE_CYCLES for COMPUTE; stall only extends FETCH.
module tpu_sequencer #(
    parameter int IMEM_DEPTH     = 8,
    parameter int IMEM_AW        = 3,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_data,
    output logic [12:0]        base_address,
    output logic               load_weight,
    output logic               load_input,
    output logic               valid,
    output logic               store,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_COMPUTE, S_DONE, S_ERROR
    } state_t;

    localparam logic [2:0] OP_HALT        = 3'b000;
    localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] OP_LOAD_INPUT  = 3'b011;
    localparam logic [2:0] OP_COMPUTE     = 3'b100;
    localparam logic [2:0] OP_STORE       = 3'b101;

    localparam int                 CW       = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(COMPUTE_CYCLES - 1);
    localparam logic [IMEM_AW-1:0] PC_LAST  = IMEM_AW'(IMEM_DEPTH - 1);

    state_t             state, state_nxt;
    logic [IMEM_AW-1:0] pc, pc_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               ovf_pend, ovf_nxt;
    logic [12:0]        base_nxt;
    logic [1:0]         err_nxt;
    logic               lw_nxt, li_nxt, st_nxt, valid_nxt, busy_nxt, done_nxt;

    logic [2:0] op;
    logic       at_last;
    logic       cnt_end;

    assign op        = imem_data[15:13];
    assign at_last   = (pc == PC_LAST);
    assign cnt_end   = (cnt == CNT_LAST);
    assign imem_en   = (state == S_FETCH) && !stall;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start)                state_nxt = S_FETCH;
                else if (state == S_DONE) state_nxt = S_IDLE;
            end
            S_FETCH:   if (!stall) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_HALT:    state_nxt = S_DONE;
                    OP_COMPUTE: state_nxt = S_COMPUTE;
                    OP_LOAD_ADDR, OP_LOAD_WEIGHT, OP_LOAD_INPUT, OP_STORE:
                                state_nxt = at_last ? S_ERROR : S_FETCH;
                    default:    state_nxt = S_ERROR;
                endcase
            end
            S_COMPUTE: if (cnt_end) state_nxt = ovf_pend ? S_ERROR : S_FETCH;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        pc_nxt   = pc;
        cnt_nxt  = cnt;
        ovf_nxt  = ovf_pend;
        base_nxt = base_address;
        err_nxt  = err;
        lw_nxt   = 1'b0;
        li_nxt   = 1'b0;
        st_nxt   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    pc_nxt  = '0;
                    err_nxt = 2'b00;
                end
            end
            S_DECODE: begin
                pc_nxt = pc + IMEM_AW'(1);
                case (op)
                    OP_HALT:        ;
                    OP_LOAD_ADDR:   base_nxt = imem_data[12:0];
                    OP_LOAD_WEIGHT: lw_nxt = 1'b1;
                    OP_LOAD_INPUT:  li_nxt = 1'b1;
                    OP_STORE:       st_nxt = 1'b1;
                    OP_COMPUTE: begin
                        cnt_nxt = '0;
                        ovf_nxt = at_last;
                    end
                    default:        err_nxt = 2'b01;
                endcase
                if (at_last && (op inside {OP_LOAD_ADDR, OP_LOAD_WEIGHT, OP_LOAD_INPUT, OP_STORE}))
                    err_nxt = 2'b10;
            end
            S_COMPUTE: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt_end && ovf_pend) err_nxt = 2'b10;
            end
            default: ;
        endcase
        valid_nxt = (state_nxt == S_COMPUTE);
        busy_nxt  = (state_nxt == S_FETCH) || (state_nxt == S_DECODE) || (state_nxt == S_COMPUTE);
        done_nxt  = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            cnt          <= '0;
            ovf_pend     <= 1'b0;
            base_address <= '0;
            err          <= 2'b00;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            store        <= 1'b0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            pc           <= pc_nxt;
            cnt          <= cnt_nxt;
            ovf_pend     <= ovf_nxt;
            base_address <= base_nxt;
            err          <= err_nxt;
            load_weight  <= lw_nxt;
            load_input   <= li_nxt;
            store        <= st_nxt;
            valid        <= valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: per-cycle expected outputs are queued when a program is started
// and popped at each falling edge.
module tb_tpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        imem_en;
    logic [2:0]  imem_addr;
    logic [15:0] imem_data;
    logic [12:0] base_address;
    logic        load_weight, load_input, valid, store, busy, done;
    logic [1:0]  err;

    tpu_sequencer #(.IMEM_DEPTH(8), .IMEM_AW(3), .COMPUTE_CYCLES(6)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .base_address(base_address), .load_weight(load_weight), .load_input(load_input),
        .valid(valid), .store(store), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [8];
    always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

    typedef struct packed {
        logic [12:0] base;
        logic        lw, li, vld, st, bsy, dn;
        logic [1:0]  err;
    } obs_t;

    typedef struct { int kind; int first; int last; } ev_t;
    typedef struct { int stall_len; int ncyc; } scen_t;

    ev_t   ev [6];
    scen_t scen [2];
    obs_t  exp_q [$];
    int    checks = 0;
    int    errors = 0;
    logic [12:0] b_exp;

    function automatic obs_t obs();
        obs_t o;
        o = '{base: base_address, lw: load_weight, li: load_input, vld: valid,
              st: store, bsy: busy, dn: done, err: err};
        return o;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    function automatic int sh(int v, int s);
        return (v > 3) ? v + s : v;
    endfunction

    // Default program expectation; the stall sits in cycles 3.. so later events shift by s.
    function automatic obs_t exp_default(int c, int s, logic [12:0] b0);
        obs_t e;
        e = '0;
        e.base = b0;
        if (c >= 3)         e.base = 13'h000F;
        if (c >= sh(7, s))  e.base = 13'h001E;
        if (c >= sh(19, s)) e.base = 13'h0007;
        for (int i = 0; i < 6; i++) begin
            if (c >= sh(ev[i].first, s) && c <= sh(ev[i].last, s)) begin
                case (ev[i].kind)
                    0: e.lw  = 1'b1;
                    1: e.li  = 1'b1;
                    2: e.vld = 1'b1;
                    3: e.st  = 1'b1;
                    4: e.dn  = 1'b1;
                    default: e.bsy = 1'b1;
                endcase
            end
        end
        return e;
    endfunction

    task automatic run(int ncyc, int stall_len, string tag);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_c%0d actual=output expected=none queued", tag, c);
            end else begin
                check($sformatf("%s_c%0d", tag, c), 32'(obs()), 32'(exp_q.pop_front()));
            end
            stall = (c >= 3) && (c < 3 + stall_len);
        end
        stall = 1'b0;
    endtask

    task automatic idle_check(int n, logic [12:0] b, string tag);
        obs_t e;
        e = '0;
        e.base = b;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, c), {11'd0, imem_en, obs()}, {11'd0, 1'b0, e});
        end
    endtask

    task automatic load_default();
        mem[0] = 16'h200F; mem[1] = 16'h4000; mem[2] = 16'h201E; mem[3] = 16'h6000;
        mem[4] = 16'h8000; mem[5] = 16'h2007; mem[6] = 16'hA000; mem[7] = 16'h0000;
    endtask

    initial begin
        obs_t e;
        ev[0] = '{0, 5, 5};   ev[1] = '{1, 9, 9};   ev[2] = '{2, 11, 16};
        ev[3] = '{3, 21, 21}; ev[4] = '{4, 23, 23}; ev[5] = '{5, 1, 22};
        scen[0] = '{0, 24};
        scen[1] = '{3, 27};

        reset = 1'b0; start = 1'b0; stall = 1'b0;
        load_default();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        idle_check(10, 13'h0, "idle");

        b_exp = 13'h0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 1; c <= scen[i].ncyc; c++)
                exp_q.push_back(exp_default(c, scen[i].stall_len, b_exp));
            run(scen[i].ncyc, scen[i].stall_len, $sformatf("prog_s%0d", scen[i].stall_len));
            b_exp = 13'h0007;
        end

        // Illegal opcode in the second instruction; the second pass checks that start clears err.
        mem[1] = 16'hC000;
        for (int k = 0; k < 2; k++) begin
            for (int c = 1; c <= 8; c++) begin
                e = '0;
                e.base = (c >= 3) ? 13'h000F : b_exp;
                e.bsy  = (c <= 4);
                e.err  = (c >= 5) ? 2'b01 : 2'b00;
                exp_q.push_back(e);
            end
            run(8, 0, $sformatf("illegal%0d", k));
            b_exp = 13'h000F;
        end

        // Eight COMPUTEs and no HALT: pc runs off the end.
        for (int i = 0; i < 8; i++) mem[i] = 16'h8000;
        for (int c = 1; c <= 70; c++) begin
            e = '0;
            e.base = b_exp;
            e.bsy  = (c <= 64);
            e.err  = (c >= 65) ? 2'b10 : 2'b00;
            for (int k = 0; k < 8; k++)
                if (c >= 8 * k + 3 && c <= 8 * k + 8) e.vld = 1'b1;
            exp_q.push_back(e);
        end
        run(70, 0, "overflow");

        // Asynchronous reset in the middle of the compute phase.
        load_default();
        for (int c = 1; c <= 12; c++) exp_q.push_back(exp_default(c, 0, b_exp));
        run(12, 0, "pre_rst");
        #1 reset = 1'b0;
        #1 check("rst_async_valid_busy", {30'd0, valid, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        idle_check(3, 13'h0, "post_rst");
        for (int c = 1; c <= 24; c++) exp_q.push_back(exp_default(c, 0, 13'h0));
        run(24, 0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_sequencer.md
# tpu_sequencer

Instruction sequencer for the tiny TPU. It fetches 16-bit instructions from an external instruction memory and decodes them. It drives the `control_unit`-level strobes (`base_address`, `load_weight`, `load_input`, `valid`, `store`) that step the weight memory, input setup, MMU, accumulators and unified buffer. Programs are run with a start/busy/done handshake, which replaces the free-running top-level fetch/execute FSM.

## Interface
- `IMEM_DEPTH`, default 8: instruction memory entries; power of two, ≥2.
- `IMEM_AW`, default 3: instruction address width, equal to log2(`IMEM_DEPTH`).
- `COMPUTE_CYCLES`, default 6: cycles `valid` is held per COMPUTE; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin program at address 0; sampled only in IDLE, DONE or ERROR.
- `stall` in 1: downstream not ready; holds sequencer in FETCH.
- `imem_en` out 1: instruction memory read enable.
- `imem_addr` out `IMEM_AW`: instruction memory read address (= pc).
- `imem_data` in 16: read data, valid the cycle after `imem_en`.
- `base_address` out 13: address register driving weight memory and unified buffer.
- `load_weight` out 1: one-cycle strobe.
- `load_input` out 1: one-cycle strobe.
- `valid` out 1: compute-phase enable for input setup, MMU and accumulators.
- `store` out 1: one-cycle strobe.
- `busy` out 1: program running.
- `done` out 1: one-cycle pulse on HALT.
- `err` out 2: 00 none, 01 illegal opcode, 10 pc overflow; sticky until next accepted `start`.

## Operation
- Instruction format: `[15:13]` opcode, `[12:0]` immediate.
- Opcodes:
  - 000 HALT
  - 001 LOAD_ADDR
  - 010 LOAD_WEIGHT
  - 011 LOAD_INPUT
  - 100 COMPUTE
  - 101 STORE
  - 110 and 111 illegal
- States: IDLE, FETCH, DECODE, COMPUTE, DONE, ERROR.
- IDLE: on `start`=1, set pc←0 and err←00, then go to FETCH. Otherwise stay in IDLE.
- FETCH:
  - `stall`=0: `imem_en`=1 with `imem_addr`=pc, then go to DECODE.
  - `stall`=1: `imem_en`=0, stay in FETCH.
- DECODE: decode `imem_data` and set pc←pc+1.
  - LOAD_ADDR: `base_address`←imm, go to FETCH.
  - LOAD_WEIGHT, LOAD_INPUT, STORE: assert the matching strobe next cycle, go to FETCH.
  - COMPUTE: clear the cycle counter, go to COMPUTE.
  - HALT: go to DONE.
  - Illegal opcode: err←01, go to ERROR.
  - Non-HALT instruction at pc = `IMEM_DEPTH`−1: err←10, go to ERROR, after that instruction's strobe or compute phase completes (COMPUTE exits to ERROR instead of FETCH).
- COMPUTE: `valid`=1. The counter increments each cycle. Leave after exactly `COMPUTE_CYCLES` cycles to FETCH, or to ERROR in the overflow case. `stall` is ignored.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` in DONE is accepted and behaves as in IDLE.
- ERROR: hold, `busy`=0. `start` restarts as in IDLE.
- `busy`=1 in FETCH, DECODE and COMPUTE; `start` is ignored there.
- Immediate bits of non-LOAD_ADDR instructions are ignored. `base_address` persists across programs until reset.

## Timing
- Reset (`reset`=0, asynchronous) puts the block in IDLE with all outputs 0: pc=0, `base_address`=0, `err`=00, counter=0.
- Reset mid-program aborts immediately, with no strobes after release.
- All outputs are registered except `imem_en` and `imem_addr`, which decode from state and pc.
- `start` sampled at edge N makes FETCH the state in cycle N+1.
- Non-COMPUTE instruction: 2 cycles (FETCH, DECODE) plus any stall cycles.
- Strobes and `base_address` update appear in the cycle after DECODE, concurrent with the next FETCH. Each strobe is exactly one cycle wide.
- COMPUTE instruction: FETCH, DECODE, then `COMPUTE_CYCLES` cycles with `valid`=1. `valid` is contiguous.
- HALT: FETCH, DECODE, DONE (`done`=1, `busy`=0), IDLE.
- `stall` only extends FETCH. It never truncates a strobe or `valid`.

## Test plan
- Reset then idle: release `reset` with `start`=0 for 10 cycles → all outputs 0, `imem_en` never 1.
- Default program (LOAD_ADDR 0x000F, LOAD_WEIGHT, LOAD_ADDR 0x001E, LOAD_INPUT, COMPUTE, LOAD_ADDR 0x0007, STORE, HALT), `start` at edge 0:
  - `load_weight` is 1 only in cycle 5 with `base_address`=0x000F.
  - `load_input` is 1 only in cycle 9 with `base_address`=0x001E.
  - `valid`=1 in cycles 11–16.
  - `store`=1 only in cycle 21 with `base_address`=0x0007.
  - `done`=1 in cycle 23.
  - `busy` is 1 in cycles 1–22.
- Stall: same program with `stall`=1 for 3 cycles during the second FETCH → every event after it shifts by 3 cycles and pulse widths are unchanged.
- Illegal opcode: instruction 2 = 0xC000 → `err`=01 and `busy`=0 from cycle 5, no strobes after the first instruction; a new `start` clears `err`.
- Overflow: 8 entries of COMPUTE, no HALT → eight 6-cycle `valid` bursts, then `err`=10 and `done` is never asserted.
- Async reset asserted during `valid` → `valid` and `busy` drop without waiting for a clock edge; the next `start` restarts at pc=0.
